// File: rtl/event_packetizer_pkg.sv
// event_packetizer_pkg: frame constants, FSM encoding and checksum helper
package event_packetizer_pkg;
    localparam logic [7:0] FRAME_SYNC = 8'hA5;
    localparam int EVT_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, CSUM = 2'd3} state_t;
    function automatic logic [7:0] xor_bytes(input logic [EVT_W-1:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction
endpackage

// File: rtl/event_packetizer_if.sv
// event_packetizer_if: event input, byte stream and overflow status bundle
interface event_packetizer_if import event_packetizer_pkg::*; #(
    parameter int FIFO_DEPTH = 16
);
    logic [EVT_W-1:0] evt_data;
    logic evt_valid;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic ovf_clr;
    logic overflow;
    logic [15:0] drop_count;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic busy;
    modport master (
        output evt_data, evt_valid, tx_ready, ovf_clr,
        input tx_data, tx_valid, overflow, drop_count, fifo_level, busy
    );
    modport slave (
        input evt_data, evt_valid, tx_ready, ovf_clr,
        output tx_data, tx_valid, overflow, drop_count, fifo_level, busy
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO, DEPTH a power of 2
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_wr, do_rd;
    assign full = level == FULL_LVL;
    assign empty = level == '0;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_wr);
            rd_ptr <= rd_ptr + AW'(do_rd);
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/event_packetizer.sv
// event_packetizer: buffers event words and sends each as sync, 4 data bytes MSB-first, xor checksum
module event_packetizer import event_packetizer_pkg::*; #(
    parameter int FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE = FRAME_SYNC
) (
    input logic clk,
    input logic rst,
    event_packetizer_if.slave bus
);
    state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [EVT_W-1:0] shift_reg, shift_n, rd_data;
    logic [7:0] csum, csum_n, byte_n;
    logic full, empty, rd_en, drop, accept;
    assign accept = bus.tx_valid && bus.tx_ready;
    // a full FIFO drops the event even if a pop frees a slot this cycle
    assign drop = bus.evt_valid && full;
    sync_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(bus.evt_valid && !full),
        .wr_data(bus.evt_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .full(full),
        .empty(empty),
        .level(bus.fifo_level)
    );
    always_comb begin
        state_n = state;
        idx_n = idx;
        shift_n = shift_reg;
        csum_n = csum;
        rd_en = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                rd_en = 1'b1;
                shift_n = rd_data;
                csum_n = xor_bytes(rd_data);
                state_n = SYNC;
            end
            SYNC: if (accept) begin
                state_n = DATA;
                idx_n = 2'd3;
            end
            DATA: if (accept) begin
                idx_n = idx - 2'd1;
                state_n = idx == 2'd0 ? CSUM : DATA;
            end
            default: if (accept) state_n = IDLE;
        endcase
        // outputs are registered, so the byte is chosen from the next state
        byte_n = state_n == SYNC ? SYNC_BYTE :
                 state_n == DATA ? shift_n[{idx_n, 3'b000} +: 8] :
                 state_n == CSUM ? csum_n : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            shift_reg <= '0;
            csum <= '0;
            bus.tx_data <= '0;
            bus.tx_valid <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            shift_reg <= shift_n;
            csum <= csum_n;
            bus.tx_data <= byte_n;
            bus.tx_valid <= state_n != IDLE;
            bus.busy <= state_n != IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow <= 1'b0;
            bus.drop_count <= '0;
        end else if (drop) begin
            bus.overflow <= 1'b1;
            bus.drop_count <= bus.ovf_clr ? 16'd1 : (&bus.drop_count ? bus.drop_count : bus.drop_count + 16'd1);
        end else if (bus.ovf_clr) begin
            bus.overflow <= 1'b0;
            bus.drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_event_packetizer.sv
// tb_event_packetizer: directed scenario tasks for event_packetizer
module tb_event_packetizer;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] cap_b[$];
    int cap_c[$];

    event_packetizer_if #(.FIFO_DEPTH(16)) bus();
    event_packetizer #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (bus.tx_valid && bus.tx_ready) begin
                cap_b.push_back(bus.tx_data);
                cap_c.push_back(cyc);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.evt_valid = 1'b0;
        bus.evt_data = '0;
        bus.tx_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        step();
        step();
        checks++;
        if ({bus.tx_data, bus.tx_valid, bus.busy} !== 10'h0) begin
            errors++;
            $display("FAIL reset_tx data=%h valid=%b busy=%b, want 0", bus.tx_data, bus.tx_valid, bus.busy);
        end
        checks++;
        if ({bus.overflow, bus.drop_count} !== 17'h0) begin
            errors++;
            $display("FAIL reset_ovf overflow=%b drop_count=%0d, want 0", bus.overflow, bus.drop_count);
        end
        checks++;
        if (bus.fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_level got %0d want 0", bus.fifo_level);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0] exp [6];
        exp = '{8'hA5, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h93};
        bus.tx_ready = 1'b1;
        bus.evt_data = 32'h0000C350;
        bus.evt_valid = 1'b1;
        step();
        bus.evt_valid = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL single_n1 valid=%b level=%0d, want 0/1", bus.tx_valid, bus.fifo_level);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin
                errors++;
                $display("FAIL single_byte%0d valid=%b data=%h, want 1/%h", i, bus.tx_valid, bus.tx_data, exp[i]);
            end
        end
        step();
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL single_end valid=%b level=%0d, want 0/0", bus.tx_valid, bus.fifo_level);
        end
    endtask

    task automatic test_toggle();
        logic [7:0] exp [6];
        logic [7:0] prev_d;
        logic stall;
        exp = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        stall = 1'b0;
        prev_d = '0;
        cap_b.delete();
        bus.tx_ready = 1'b0;
        bus.evt_data = 32'hDEADBEEF;
        bus.evt_valid = 1'b1;
        step();
        bus.evt_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.tx_ready = i[0];
            if (stall) begin
                checks++;
                if (bus.tx_data !== prev_d) begin
                    errors++;
                    $display("FAIL toggle_hold data=%h want %h", bus.tx_data, prev_d);
                end
            end
            stall = bus.tx_valid && !bus.tx_ready;
            prev_d = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) cap_b.push_back(bus.tx_data);
            step();
        end
        checks++;
        if (cap_b.size() != 6) begin
            errors++;
            $display("FAIL toggle_count handshakes=%0d want 6", cap_b.size());
        end
        for (int k = 0; k < 6 && k < cap_b.size(); k++) begin
            checks++;
            if (cap_b[k] !== exp[k]) begin
                errors++;
                $display("FAIL toggle_byte%0d got %h want %h", k, cap_b[k], exp[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        logic [7:0] e;
        bus.tx_ready = 1'b0;
        bus.evt_data = 32'hCAFE0000;
        bus.evt_valid = 1'b1;
        step();
        bus.evt_valid = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b1 || bus.fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL ovf_preload busy=%b level=%0d, want 1/0", bus.busy, bus.fifo_level);
        end
        for (int i = 1; i <= 17; i++) begin
            bus.evt_data = 32'(i);
            bus.evt_valid = 1'b1;
            step();
        end
        bus.evt_valid = 1'b0;
        checks++;
        if (bus.fifo_level !== 5'd16 || bus.overflow !== 1'b1 || bus.drop_count !== 16'd1) begin
            errors++;
            $display("FAIL ovf_fill level=%0d ovf=%b cnt=%0d, want 16/1/1", bus.fifo_level, bus.overflow, bus.drop_count);
        end
        bus.evt_data = 32'd18;
        bus.evt_valid = 1'b1;
        step();
        checks++;
        if (bus.drop_count !== 16'd2) begin
            errors++;
            $display("FAIL ovf_incr cnt=%0d want 2", bus.drop_count);
        end
        bus.evt_data = 32'd19;
        bus.ovf_clr = 1'b1;
        step();
        bus.evt_valid = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd1) begin
            errors++;
            $display("FAIL ovf_clr_drop ovf=%b cnt=%0d, want 1/1", bus.overflow, bus.drop_count);
        end
        step();
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
            errors++;
            $display("FAIL ovf_clr ovf=%b cnt=%0d, want 0/0", bus.overflow, bus.drop_count);
        end
        cap_b.delete();
        cap_c.delete();
        bus.tx_ready = 1'b1;
        collect(140);
        checks++;
        if (cap_b.size() != 102) begin
            errors++;
            $display("FAIL ovf_drain bytes=%0d want 102", cap_b.size());
        end
        for (int f = 0; f < 17; f++) begin
            w = f == 0 ? 32'hCAFE0000 : 32'(f);
            for (int b = 0; b < 6 && f * 6 + b < cap_b.size(); b++) begin
                e = b == 0 ? 8'hA5 : b == 5 ? (w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]) : w[8*(4-b) +: 8];
                checks++;
                if (cap_b[f*6+b] !== e) begin
                    errors++;
                    $display("FAIL ovf_frame%0d_byte%0d got %h want %h", f, b, cap_b[f*6+b], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.evt_data = 32'hAABBCC10 + 32'(i);
            bus.evt_valid = 1'b1;
            step();
        end
        bus.evt_valid = 1'b0;
        checks++;
        if (bus.fifo_level !== 5'd3 || bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL rstmid_queue level=%0d data=%h, want 3/a5", bus.fifo_level, bus.tx_data);
        end
        bus.tx_ready = 1'b1;
        step();
        checks++;
        if (bus.tx_data !== 8'hAA || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_data data=%h busy=%b, want aa/1", bus.tx_data, bus.busy);
        end
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.fifo_level !== 5'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after valid=%b level=%0d busy=%b, want 0/0/0", bus.tx_valid, bus.fifo_level, bus.busy);
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet%0d valid=%b want 0", i, bus.tx_valid);
            end
        end
        bus.evt_data = 32'h12345678;
        bus.evt_valid = 1'b1;
        step();
        bus.evt_valid = 1'b0;
        step();
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL rstmid_new valid=%b data=%h, want 1/a5", bus.tx_valid, bus.tx_data);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [12];
        exp = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
                8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        cap_b.delete();
        cap_c.delete();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.evt_valid = i == 0 || i == 4;
            bus.evt_data = i == 0 ? 32'h01020304 : 32'h11223344;
            collect(1);
        end
        bus.evt_valid = 1'b0;
        checks++;
        if (cap_b.size() != 12) begin
            errors++;
            $display("FAIL b2b_count bytes=%0d want 12", cap_b.size());
        end
        for (int k = 0; k < 12 && k < cap_b.size(); k++) begin
            checks++;
            if (cap_b[k] !== exp[k]) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h want %h", k, cap_b[k], exp[k]);
            end
        end
        if (cap_c.size() >= 7) begin
            checks++;
            if (cap_c[6] - cap_c[5] != 2) begin
                errors++;
                $display("FAIL b2b_gap sync-csum distance=%0d want 2", cap_c[6] - cap_c[5]);
            end
            checks++;
            if (cap_c[5] - cap_c[0] != 5) begin
                errors++;
                $display("FAIL b2b_first_span got %0d want 5", cap_c[5] - cap_c[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
